// File: rtl/wb_dest_pipe.sv
// Write-destination select plus a configurable pipeline of {dest, valid} stages with
// stall/flush, and per-stage source-match flags for the hazard/forwarding unit.
module wb_dest_pipe #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned STAGES   = 3,
    parameter int unsigned LINK_REG = 31
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                sel,
    input  logic [REG_W-1:0]          rt_in,
    input  logic [REG_W-1:0]          rd_in,
    input  logic                      reg_write_in,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [REG_W-1:0]          src_a,
    input  logic [REG_W-1:0]          src_b,
    output logic [STAGES*REG_W-1:0]   stage_dest,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES-1:0]         haz_a,
    output logic [STAGES-1:0]         haz_b,
    output logic [REG_W-1:0]          wb_reg,
    output logic                      wb_en
);

    logic [REG_W-1:0]  dest_q [STAGES];
    logic [REG_W-1:0]  dest_d [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [REG_W-1:0]  dsel;
    logic              nv;

    always_comb begin
        dsel = '0;
        case (sel)
            2'd0:    dsel = rt_in;
            2'd1:    dsel = rd_in;
            2'd2:    dsel = REG_W'(LINK_REG);
            default: dsel = '0;
        endcase
    end

    // Writes to register 0 are stored but never become live.
    assign nv = reg_write_in && (sel != 2'd3) && (dsel != '0);

    always_comb begin
        dest_d[0]  = dsel;
        valid_d[0] = nv;
        for (int unsigned i = 1; i < STAGES; i++) begin
            dest_d[i]  = dest_q[i-1];
            valid_d[i] = valid_q[i-1];
        end
        if (flush) begin
            dest_d[0]  = '0;
            valid_d[0] = 1'b0;
            dest_d[1]  = '0;
            valid_d[1] = 1'b0;
        end else if (stall) begin
            dest_d[0]  = dest_q[0];
            valid_d[0] = valid_q[0];
            dest_d[1]  = '0;
            valid_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                dest_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                dest_q[i] <= dest_d[i];
            end
            valid_q <= valid_d;
        end
    end

    always_comb begin
        stage_dest = '0;
        haz_a      = '0;
        haz_b      = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            stage_dest[i*REG_W +: REG_W] = dest_q[i];
            haz_a[i] = valid_q[i] && (dest_q[i] == src_a);
            haz_b[i] = valid_q[i] && (dest_q[i] == src_b);
        end
    end

    assign stage_valid = valid_q;
    assign wb_reg      = dest_q[STAGES-1];
    assign wb_en       = valid_q[STAGES-1];

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Directed vector table for wb_dest_pipe (default parameters): each record gives the inputs held
// across one rising edge and the full pipe state expected just after it.
module tb_wb_dest_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sel;
    logic [4:0]  rt_in, rd_in, src_a, src_b;
    logic        reg_write_in, stall, flush;
    logic [14:0] stage_dest;
    logic [2:0]  stage_valid, haz_a, haz_b;
    logic [4:0]  wb_reg;
    logic        wb_en;

    int total = 0;
    int bad   = 0;

    wb_dest_pipe #(.REG_W(5), .STAGES(3), .LINK_REG(31)) dut (
        .clk(clk), .reset(reset), .sel(sel), .rt_in(rt_in), .rd_in(rd_in),
        .reg_write_in(reg_write_in), .stall(stall), .flush(flush),
        .src_a(src_a), .src_b(src_b), .stage_dest(stage_dest), .stage_valid(stage_valid),
        .haz_a(haz_a), .haz_b(haz_b), .wb_reg(wb_reg), .wb_en(wb_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] sel;
        logic [4:0] rt, rd;
        logic       rw, st, fl;
        logic [4:0] sa, sb;
        logic [2:0] ev;
        logic [4:0] e0, e1, e2;
        logic [2:0] ha, hb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [1:0] s, logic [4:0] rt, logic [4:0] rd,
                                logic rw, logic st, logic fl, logic [4:0] sa, logic [4:0] sb,
                                logic [2:0] ev, logic [4:0] e2, logic [4:0] e1, logic [4:0] e0,
                                logic [2:0] ha, logic [2:0] hb);
        vec_t v;
        v.rst = rst; v.sel = s; v.rt = rt; v.rd = rd; v.rw = rw; v.st = st; v.fl = fl;
        v.sa = sa; v.sb = sb; v.ev = ev; v.e0 = e0; v.e1 = e1; v.e2 = e2;
        v.ha = ha; v.hb = hb;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL vec%0d %s: got %0h expected %0h", idx, name, act, exp);
        end
    endtask

    initial begin
        //                 rst sel rt  rd rw st fl sa  sb  valid d2  d1  d0  ha    hb
        vecs.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0,  0,  3'b000, 0,  0,  0,  3'b000, 3'b000));
        // rd path, 3-edge latency
        vecs.push_back(mk(0, 1, 0,  9, 1, 0, 0, 0,  0,  3'b001, 0,  0,  9,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0,  3'b010, 0,  9,  0,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0,  3'b100, 9,  0,  0,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0,  3'b000, 0,  0,  0,  3'b000, 3'b000));
        // link register, $zero write, sel=3
        vecs.push_back(mk(0, 2, 0,  0, 1, 0, 0, 0,  0,  3'b001, 0,  0,  31, 3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 0,  0, 1, 0, 0, 0,  0,  3'b010, 0,  31, 0,  3'b000, 3'b000));
        vecs.push_back(mk(0, 3, 7,  0, 1, 0, 0, 0,  0,  3'b100, 31, 0,  0,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0,  3'b000, 0,  0,  0,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0,  3'b000, 0,  0,  0,  3'b000, 3'b000));
        // 4,5,6 with a stall while 5 is in stage 0
        vecs.push_back(mk(0, 0, 4,  0, 1, 0, 0, 0,  0,  3'b001, 0,  0,  4,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 5,  0, 1, 0, 0, 0,  0,  3'b011, 0,  4,  5,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 6,  0, 1, 1, 0, 0,  0,  3'b101, 4,  0,  5,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 6,  0, 1, 0, 0, 0,  0,  3'b011, 0,  5,  6,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0,  3'b110, 5,  6,  0,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0,  3'b100, 6,  0,  0,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0,  3'b000, 0,  0,  0,  3'b000, 3'b000));
        // flush and stall together kill stage 0 and the input
        vecs.push_back(mk(0, 0, 8,  0, 1, 0, 0, 0,  0,  3'b001, 0,  0,  8,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 10, 0, 1, 1, 1, 0,  0,  3'b000, 0,  0,  0,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0,  3'b000, 0,  0,  0,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0,  3'b000, 0,  0,  0,  3'b000, 3'b000));
        // hazard flags: 12 in stages 0 and 2, dead 3 in stage 1
        vecs.push_back(mk(0, 0, 12, 0, 1, 0, 0, 0,  0,  3'b001, 0,  0,  12, 3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 3,  0, 0, 0, 0, 0,  0,  3'b010, 0,  12, 3,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 12, 0, 1, 0, 0, 12, 3,  3'b101, 12, 3,  12, 3'b101, 3'b000));
        vecs.push_back(mk(0, 0, 0,  0, 1, 0, 0, 0,  12, 3'b010, 3,  12, 0,  3'b000, 3'b010));
        // fill the pipe, then reset mid-operation
        vecs.push_back(mk(0, 0, 1,  0, 1, 0, 0, 0,  0,  3'b101, 12, 0,  1,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 2,  0, 1, 0, 0, 0,  0,  3'b011, 0,  1,  2,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 3,  0, 1, 0, 0, 2,  0,  3'b111, 1,  2,  3,  3'b010, 3'b000));
        vecs.push_back(mk(1, 0, 4,  0, 1, 1, 1, 0,  0,  3'b000, 0,  0,  0,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 13, 0, 1, 0, 0, 0,  0,  3'b001, 0,  0,  13, 3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0,  3'b010, 0,  13, 0,  3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 13, 0,  3'b100, 13, 0,  0,  3'b100, 3'b000));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0,  3'b000, 0,  0,  0,  3'b000, 3'b000));

        for (int i = 0; i < vecs.size(); i++) begin
            reset        = vecs[i].rst;
            sel          = vecs[i].sel;
            rt_in        = vecs[i].rt;
            rd_in        = vecs[i].rd;
            reg_write_in = vecs[i].rw;
            stall        = vecs[i].st;
            flush        = vecs[i].fl;
            src_a        = vecs[i].sa;
            src_b        = vecs[i].sb;
            @(posedge clk);
            #1;
            chk("stage_valid", i, 32'(stage_valid), 32'(vecs[i].ev));
            chk("stage_dest", i, 32'(stage_dest), 32'({vecs[i].e2, vecs[i].e1, vecs[i].e0}));
            chk("wb_reg", i, 32'(wb_reg), 32'(vecs[i].e2));
            chk("wb_en", i, 32'(wb_en), 32'(vecs[i].ev[2]));
            chk("haz_a", i, 32'(haz_a), 32'(vecs[i].ha));
            chk("haz_b", i, 32'(haz_b), 32'(vecs[i].hb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
